// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD complement datapath: digit width,
// controller state encoding and the BCD constant nine.
package bcd_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : bcd_pkg

// File: rtl/bcd_digit_complement.sv
// Single-digit BCD complement cell: 9's complement of d, optionally plus the
// incoming carry. Digits above nine are flagged and produce a zero digit.
module bcd_digit_complement
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout,
  output logic             invalid
);

  logic [BCD_W-1:0] n;

  always_comb begin
    invalid = (d > BCD_NINE);
    n       = BCD_NINE - d;
    q       = n;
    cout    = 1'b0;
    if (invalid) begin
      // An invalid digit also kills the carry chain.
      q = '0;
    end else if (cin) begin
      if (n == BCD_NINE) begin
        q    = '0;
        cout = 1'b1;
      end else begin
        q = n + 1'b1;
      end
    end
  end

endmodule : bcd_digit_complement

// File: rtl/bcd_complement_serial.sv
// Digit-serial 9's/10's complement of a packed BCD operand, least-significant
// digit first, one digit per clock, with a sticky invalid-digit flag.
module bcd_complement_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      mode,
  input  logic [BCD_W*DIGITS-1:0]   din,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   dout,
  output logic                      cout,
  output logic                      err
);

  localparam int W     = BCD_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  // Handshake: start is a request sampled only in IDLE or DONE; done is a
  // one-cycle completion pulse after which dout/cout/err stay valid until
  // the next completed operation overwrites them.

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [W-1:0]     res_q, res_d;
  logic [W-1:0]     dout_q, dout_d;
  logic             carry_q, carry_d;
  logic             err_acc_q, err_acc_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic [BCD_W-1:0] dig_q;
  logic             dig_cout;
  logic             dig_invalid;
  logic [W-1:0]     res_shifted;
  logic             accept;
  logic             last_step;

  bcd_digit_complement u_digit (
    .d       (sh_q[BCD_W-1:0]),
    .cin     (carry_q),
    .q       (dig_q),
    .cout    (dig_cout),
    .invalid (dig_invalid)
  );

  // New digit enters at the MSD end so that after DIGITS steps every digit
  // sits in the same position it occupied in din.
  assign res_shifted = W'({dig_q, res_q} >> BCD_W);

  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_step = (state_q == RUN) && (cnt_q == CNT_LAST);

  // State register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      err_acc_q <= 1'b0;
      dout_q    <= '0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      err_acc_q <= err_acc_d;
      dout_q    <= dout_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values.
  always_comb begin
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    res_d     = res_q;
    carry_d   = carry_q;
    err_acc_d = err_acc_q;
    dout_d    = dout_q;
    cout_d    = cout_q;
    err_d     = err_q;
    if (accept) begin
      // The captured mode is the carry into the least-significant digit.
      sh_d      = din;
      carry_d   = mode;
      cnt_d     = '0;
      err_acc_d = 1'b0;
      res_d     = '0;
    end else if (state_q == RUN) begin
      sh_d      = sh_q >> BCD_W;
      carry_d   = dig_cout;
      err_acc_d = err_acc_q | dig_invalid;
      res_d     = res_shifted;
      cnt_d     = last_step ? '0 : cnt_q + 1'b1;
      if (last_step) begin
        dout_d = res_shifted;
        cout_d = dig_cout;
        err_d  = err_acc_q | dig_invalid;
      end
    end
  end

  assign dout = dout_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule : bcd_complement_serial
